game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 16 +
 rtl/bcd_sat_add.sv | 38 +++
 rtl/game_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game controller and the display block:
// state encodings and default scoring weights.
package game_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_PLAY  = 2'b01,
        ST_OVER  = 2'b10
    } game_state_t;

    localparam int PTS_K_DEF = 1;
    localparam int PTS_H_DEF = 4;

    localparam logic [2:0] PEND_MAX = 3'd7;

endpackage

// File: rtl/bcd_sat_add.sv
// Two-digit BCD plus a small binary addend, saturating at 99.
// Purely combinational; both result digits are always valid BCD.
module bcd_sat_add (
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic [3:0] addend,
    output logic [3:0] sum_tens,
    output logic [3:0] sum_units
);

    logic [4:0] u_raw;
    logic [4:0] t_raw;
    logic [3:0] u_dig;
    logic [1:0] carry;

    always_comb begin
        u_raw = {1'b0, units} + {1'b0, addend};
        carry = 2'd0;
        u_dig = u_raw[3:0];
        // units + addend never exceeds 24, so at most two decimal carries
        if (u_raw >= 5'd20) begin
            carry = 2'd2;
            u_dig = 4'(u_raw - 5'd20);
        end else if (u_raw >= 5'd10) begin
            carry = 2'd1;
            u_dig = 4'(u_raw - 5'd10);
        end
        t_raw = {1'b0, tens} + {3'b000, carry};
        if (t_raw > 5'd9) begin
            sum_tens  = 4'd9;
            sum_units = 4'd9;
        end else begin
            sum_tens  = t_raw[3:0];
            sum_units = u_dig;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Round controller: START/PLAY/OVER FSM, tick timer, round countdown and a
// BCD score fed from per-source pending event counters through one adder.
module game_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV    = 30_000_000,
    parameter int ROUND_TICKS = 60,
    parameter int PTS_K       = PTS_K_DEF,
    parameter int PTS_H       = PTS_H_DEF
) (
    input  logic       CLK_50M,
    input  logic       RST,
    input  logic       btn_start,
    input  logic       score_k,
    input  logic       score_h,
    input  logic       player_dead,
    output logic [1:0] game_state,
    output logic [3:0] score_units,
    output logic [3:0] score_tens,
    output logic [6:0] time_left,
    output logic       tick
);

    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    game_state_t      state;
    logic             btn_prev;
    logic [CNT_W-1:0] tick_cnt;
    logic [2:0]       pend_k;
    logic [2:0]       pend_h;

    logic       btn_rise;
    logic       serve_h;
    logic       serve_k;
    logic       end_round;
    logic       wrap;
    logic [3:0] addend;
    logic [3:0] sum_tens;
    logic [3:0] sum_units;

    // Arrival and service in the same cycle cancel; arrivals at the cap are dropped.
    function automatic logic [2:0] pend_next(input logic [2:0] cnt, input logic evt,
                                             input logic served);
        if (evt && !served)
            return (cnt == PEND_MAX) ? cnt : cnt + 3'd1;
        if (!evt && served)
            return cnt - 3'd1;
        return cnt;
    endfunction

    assign btn_rise   = btn_start & ~btn_prev;
    assign serve_h    = (pend_h != 3'd0);
    assign serve_k    = !serve_h && (pend_k != 3'd0);
    assign addend     = serve_h ? 4'(PTS_H) : 4'(PTS_K);
    assign end_round  = player_dead || (time_left == 7'd0);
    assign wrap       = (tick_cnt == CNT_LAST);
    assign game_state = state;

    bcd_sat_add u_add (
        .tens      (score_tens),
        .units     (score_units),
        .addend    (addend),
        .sum_tens  (sum_tens),
        .sum_units (sum_units)
    );

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state       <= ST_START;
            btn_prev    <= 1'b1;
            tick_cnt    <= '0;
            pend_k      <= 3'd0;
            pend_h      <= 3'd0;
            score_units <= 4'd0;
            score_tens  <= 4'd0;
            time_left   <= 7'd0;
            tick        <= 1'b0;
        end else begin
            btn_prev <= btn_start;
            tick     <= 1'b0;
            case (state)
                ST_START: begin
                    if (btn_rise) begin
                        state       <= ST_PLAY;
                        score_units <= 4'd0;
                        score_tens  <= 4'd0;
                        time_left   <= 7'(ROUND_TICKS);
                        tick_cnt    <= '0;
                        pend_k      <= 3'd0;
                        pend_h      <= 3'd0;
                    end
                end
                ST_PLAY: begin
                    // Leaving PLAY discards anything still pending, unserved.
                    if (end_round) begin
                        state  <= ST_OVER;
                        pend_k <= 3'd0;
                        pend_h <= 3'd0;
                    end else begin
                        tick_cnt <= wrap ? '0 : tick_cnt + CNT_W'(1);
                        if (wrap) begin
                            tick      <= 1'b1;
                            time_left <= time_left - 7'd1;
                        end
                        pend_h <= pend_next(pend_h, score_h, serve_h);
                        pend_k <= pend_next(pend_k, score_k, serve_k);
                        if (serve_h || serve_k) begin
                            score_tens  <= sum_tens;
                            score_units <= sum_units;
                        end
                    end
                end
                ST_OVER: begin
                    if (btn_rise) begin
                        state       <= ST_START;
                        score_units <= 4'd0;
                        score_tens  <= 4'd0;
                        time_left   <= 7'd0;
                    end
                end
                default: state <= ST_START;
            endcase
        end
    end

endmodule
